// File: rtl/afe_rx_iq_packer_pkg.sv
// Shared widths, the I/Q phase type and the word-packing helper for the AFE RX IQ packer.
package afe_rx_iq_packer_pkg;

  localparam int SAMPLE_W        = 12;
  localparam int IQ_PAIR_W       = 2 * SAMPLE_W;
  localparam int WORD_W          = 32;
  localparam int PAIRS_PER_GROUP = 4;
  localparam int WORDS_PER_GROUP = 3;
  localparam int HOLD_W          = IQ_PAIR_W * (PAIRS_PER_GROUP - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    WANT_Q = 1'b1
  } iq_phase_t;

  typedef logic [IQ_PAIR_W-1:0] iq_pair_t;

  // Group bitstream is P0..P3 LSB-first; completing pair idx (1..3) closes word idx-1.
  function automatic logic [WORD_W-1:0] pack_word(input logic [1:0]        idx,
                                                  input logic [HOLD_W-1:0] hold,
                                                  input iq_pair_t          pair);
    logic [WORD_W-1:0] w;
    case (idx)
      2'd1:    w = {pair[7:0],  hold[23:0]};
      2'd2:    w = {pair[15:0], hold[47:32]};
      default: w = {pair[23:0], hold[71:64]};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/afe_rx_iq_packer_if.sv
// Sample input and packed-word output stream of the AFE RX IQ packer.
interface afe_rx_iq_packer_if;
  import afe_rx_iq_packer_pkg::*;

  logic                rx_valid;
  logic [SAMPLE_W-1:0] rx_d;
  logic                rx_sel;
  logic [WORD_W-1:0]   out_data;
  logic                out_valid;
  logic                out_ready;

  // master: ADC source plus word consumer; slave: the packer
  modport master (
    output rx_valid, rx_d, rx_sel, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  rx_valid, rx_d, rx_sel, out_ready,
    output out_data, out_valid
  );

endinterface

// File: rtl/afe_rx_iq_packer_word_fifo.sv
// Synchronous first-word fall-through word FIFO with occupancy count for admission checks.
module afe_rx_iq_packer_word_fifo #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 8,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              empty_o,
  output logic [CW-1:0]     count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              full;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: ;
    endcase
  end

  // NOTE: storage has no reset; validity comes only from the reset pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/afe_rx_iq_packer.sv
// Pairs interleaved 12-bit I/Q samples and packs groups of 4 pairs into 3 32-bit words,
// dropping whole groups when the output FIFO cannot hold them; keeps sync/overrun stats.
module afe_rx_iq_packer
  import afe_rx_iq_packer_pkg::*;
#(
  parameter int OUT_DEPTH = 8,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 test_mode,
  input  logic                 clr_stats,
  afe_rx_iq_packer_if.slave    io,
  output logic                 overrun,
  output logic [CNT_W-1:0]     sync_err_cnt,
  output logic [CNT_W-1:0]     drop_cnt
);

  localparam int CW = $clog2(OUT_DEPTH) + 1;

  iq_phase_t           phase_q, phase_d;
  logic [SAMPLE_W-1:0] i_hold_q, i_hold_d;
  logic [1:0]          pair_idx_q, pair_idx_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                drop_group_q, drop_group_d;
  logic [SAMPLE_W-1:0] tctr_q, tctr_d;
  logic                push_q, push_d;
  logic [WORD_W-1:0]   push_data_q, push_data_d;
  logic                overrun_q, overrun_d;
  logic [CNT_W-1:0]    sync_err_q, sync_err_d;
  logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;

  logic [SAMPLE_W-1:0] sample;
  iq_pair_t            cur_pair;
  logic                is_i, is_q;
  logic                pair_done, sync_err, group_start, admit_ok;
  logic [CW:0]         used;

  logic [WORD_W-1:0]   fifo_head;
  logic                fifo_empty;
  logic [CW-1:0]       fifo_count;
  logic                pop;

  // Sample decode and group admission
  always_comb begin
    sample      = test_mode ? (io.rx_sel ? tctr_q : ~tctr_q) : io.rx_d;
    cur_pair    = {sample, i_hold_q};
    is_i        = en && io.rx_valid && io.rx_sel;
    is_q        = en && io.rx_valid && !io.rx_sel;
    pair_done   = is_q && (phase_q == WANT_Q);
    sync_err    = (is_q && (phase_q == IDLE)) || (is_i && (phase_q == WANT_Q));
    group_start = is_i && (phase_q == IDLE) && (pair_idx_q == 2'd0);
    // The word still in the push register already owns a FIFO slot.
    used        = {1'b0, fifo_count} + (CW+1)'(push_q);
    admit_ok    = (used <= (CW+1)'(OUT_DEPTH - WORDS_PER_GROUP));
  end

  // Next-state logic
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    phase_d      = phase_q;
    i_hold_d     = i_hold_q;
    pair_idx_d   = pair_idx_q;
    hold_d       = hold_q;
    drop_group_d = drop_group_q;
    tctr_d       = tctr_q;
    push_d       = 1'b0;
    push_data_d  = push_data_q;
    overrun_d    = overrun_q;
    sync_err_d   = sync_err_q;
    drop_cnt_d   = drop_cnt_q;

    if (!en) begin
      phase_d      = IDLE;
      i_hold_d     = '0;
      pair_idx_d   = '0;
      hold_d       = '0;
      drop_group_d = 1'b0;
      tctr_d       = '0;
    end else begin
      if (is_i) begin
        i_hold_d = sample;
        phase_d  = WANT_Q;
      end
      if (group_start) drop_group_d = !admit_ok;
      if (pair_done) begin
        phase_d    = IDLE;
        pair_idx_d = pair_idx_q + 2'd1;
        if (test_mode) tctr_d = tctr_q + SAMPLE_W'(1);
        case (pair_idx_q)
          2'd0:    hold_d[IQ_PAIR_W-1:0]             = cur_pair;
          2'd1:    hold_d[2*IQ_PAIR_W-1:IQ_PAIR_W]   = cur_pair;
          2'd2:    hold_d[3*IQ_PAIR_W-1:2*IQ_PAIR_W] = cur_pair;
          default: ;
        endcase
        if ((pair_idx_q != 2'd0) && !drop_group_q) begin
          push_d      = 1'b1;
          push_data_d = pack_word(pair_idx_q, hold_q, cur_pair);
        end
      end
    end

    if (sync_err && (sync_err_q != '1)) sync_err_d = sync_err_q + CNT_W'(1);
    if (group_start && !admit_ok) begin
      overrun_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
    if (clr_stats) begin
      overrun_d  = 1'b0;
      sync_err_d = '0;
      drop_cnt_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q      <= IDLE;
      i_hold_q     <= '0;
      pair_idx_q   <= '0;
      hold_q       <= '0;
      drop_group_q <= 1'b0;
      tctr_q       <= '0;
      push_q       <= 1'b0;
      push_data_q  <= '0;
      overrun_q    <= 1'b0;
      sync_err_q   <= '0;
      drop_cnt_q   <= '0;
    end else begin
      phase_q      <= phase_d;
      i_hold_q     <= i_hold_d;
      pair_idx_q   <= pair_idx_d;
      hold_q       <= hold_d;
      drop_group_q <= drop_group_d;
      tctr_q       <= tctr_d;
      push_q       <= push_d;
      push_data_q  <= push_data_d;
      overrun_q    <= overrun_d;
      sync_err_q   <= sync_err_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign pop = io.out_valid && io.out_ready;

  afe_rx_iq_packer_word_fifo #(
    .DATA_W (WORD_W),
    .DEPTH  (OUT_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push_q),
    .push_data_i (push_data_q),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Data is forced to zero while empty so reset shows a clean bus without clearing storage.
  always_comb begin
    io.out_valid = !fifo_empty;
    io.out_data  = fifo_empty ? '0 : fifo_head;
  end

  assign overrun      = overrun_q;
  assign sync_err_cnt = sync_err_q;
  assign drop_cnt     = drop_cnt_q;

endmodule
